// File: rtl/rtc_bcd_settable_if.sv
// ---------------------------------------------------------------------------
// rtc_bcd_settable_if
// Bundles the control, load, alarm and time-display signals of
// rtc_bcd_settable. The clock and reset are plain ports on the RTC itself.
//   master : SoC / register-block side. Drives run, mode12, load, ld_*,
//            alarm_set, al_*, alarm_ack. Reads hr, min, sec, pm, sec_tick,
//            alarm, load_err.
//   slave  : RTC side, with the opposite directions.
// ---------------------------------------------------------------------------
interface rtc_bcd_settable_if;
    logic       run;
    logic       mode12;
    logic       load;
    logic [7:0] ld_hr;
    logic [7:0] ld_min;
    logic [7:0] ld_sec;
    logic       alarm_set;
    logic [7:0] al_hr;
    logic [7:0] al_min;
    logic       alarm_ack;
    logic [7:0] hr;
    logic [7:0] min;
    logic [7:0] sec;
    logic       pm;
    logic       sec_tick;
    logic       alarm;
    logic       load_err;

    modport master (
        output run, mode12, load, ld_hr, ld_min, ld_sec,
        output alarm_set, al_hr, al_min, alarm_ack,
        input  hr, min, sec, pm, sec_tick, alarm, load_err
    );

    modport slave (
        input  run, mode12, load, ld_hr, ld_min, ld_sec,
        input  alarm_set, al_hr, al_min, alarm_ack,
        output hr, min, sec, pm, sec_tick, alarm, load_err
    );
endinterface

// File: rtl/rtc_bcd_settable.sv
// ---------------------------------------------------------------------------
// rtc_bcd_settable
// BCD real-time clock (hh:mm:ss, 24-hour internal) advanced by a prescaler
// running in the hundred_clk domain. Supports run/stop, range-checked time
// load, 12/24-hour display and an hh:mm alarm with a sticky flag.
// Parameters:
//   TICKS_PER_SEC : hundred_clk cycles per second (2..1023)
//   ALARM_EN      : 0 removes the alarm logic (alarm tied low)
// Ports:
//   hundred_clk   : clock, rising edge
//   rst           : asynchronous active-high reset
//   bus (slave)   : control/load/alarm inputs and time/flag outputs
// ---------------------------------------------------------------------------
module rtc_bcd_settable #(
    parameter int TICKS_PER_SEC = 100,
    parameter int ALARM_EN      = 1
) (
    input logic               hundred_clk,
    input logic               rst,
    rtc_bcd_settable_if.slave bus
);

    localparam int            PW         = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);
    localparam logic          AL_ON      = (ALARM_EN != 0);

    // True when both nibbles are decimal digits and the value does not exceed lim.
    function automatic logic bcd_ok(input logic [7:0] v, input logic [7:0] lim);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= lim);
    endfunction

    // BCD increment that wraps to 00 once lim has been reached.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] lim);
        logic [7:0] r;
        if (v == lim) begin
            r = 8'h00;
        end else if (v[3:0] == 4'h9) begin
            r = {v[7:4] + 4'h1, 4'h0};
        end else begin
            r = {v[7:4], v[3:0] + 4'h1};
        end
        return r;
    endfunction

    // 24-hour BCD hour to 12-hour BCD display value.
    function automatic logic [7:0] hr_to_12(input logic [7:0] h);
        logic [7:0] r;
        case (h)
            8'h00:   r = 8'h12;
            8'h13:   r = 8'h01;
            8'h14:   r = 8'h02;
            8'h15:   r = 8'h03;
            8'h16:   r = 8'h04;
            8'h17:   r = 8'h05;
            8'h18:   r = 8'h06;
            8'h19:   r = 8'h07;
            8'h20:   r = 8'h08;
            8'h21:   r = 8'h09;
            8'h22:   r = 8'h10;
            8'h23:   r = 8'h11;
            default: r = h;
        endcase
        return r;
    endfunction

    logic [PW-1:0] presc_r, presc_nxt_s;
    logic [7:0]    hr_r, min_r, sec_r;
    logic [7:0]    hr_nxt_s, min_nxt_s, sec_nxt_s;
    logic [7:0]    hr_inc_s, min_inc_s, sec_inc_s;
    logic [7:0]    al_hr_r, al_min_r, al_hr_nxt_s, al_min_nxt_s;
    logic          armed_r, alarm_r, load_err_r, sec_tick_r;
    logic          armed_nxt_s, alarm_nxt_s, load_err_nxt_s;
    logic          wrap_s, adv_s, ld_ok_s, al_req_s, al_ok_s, fire_s;

    // Next-state logic: prescaler, time carry chain, load/alarm validation, flags.
    always_comb begin
        wrap_s  = bus.run && (presc_r == PRESC_LAST);
        // A load request, valid or not, consumes the cycle; a coincident wrap is dropped.
        adv_s   = wrap_s && !bus.load;
        ld_ok_s = bcd_ok(bus.ld_hr, 8'h23) && bcd_ok(bus.ld_min, 8'h59)
                  && bcd_ok(bus.ld_sec, 8'h59);
        al_req_s = AL_ON && bus.alarm_set;
        al_ok_s  = bcd_ok(bus.al_hr, 8'h23) && bcd_ok(bus.al_min, 8'h59);

        sec_inc_s = bcd_inc(sec_r, 8'h59);
        min_inc_s = (sec_r == 8'h59) ? bcd_inc(min_r, 8'h59) : min_r;
        hr_inc_s  = ((sec_r == 8'h59) && (min_r == 8'h59)) ? bcd_inc(hr_r, 8'h23) : hr_r;

        // Fires only on a real advance into hh:mm:00, never on a load.
        fire_s = AL_ON && adv_s && armed_r && (sec_inc_s == 8'h00)
                 && (min_inc_s == al_min_r) && (hr_inc_s == al_hr_r);

        presc_nxt_s = presc_r;
        hr_nxt_s    = hr_r;
        min_nxt_s   = min_r;
        sec_nxt_s   = sec_r;
        if (bus.load) begin
            if (ld_ok_s) begin
                presc_nxt_s = '0;
                hr_nxt_s    = bus.ld_hr;
                min_nxt_s   = bus.ld_min;
                sec_nxt_s   = bus.ld_sec;
            end else begin
                presc_nxt_s = presc_r;
            end
        end else if (bus.run) begin
            if (wrap_s) begin
                presc_nxt_s = '0;
                hr_nxt_s    = hr_inc_s;
                min_nxt_s   = min_inc_s;
                sec_nxt_s   = sec_inc_s;
            end else begin
                presc_nxt_s = presc_r + PW'(1);
            end
        end else begin
            presc_nxt_s = presc_r;
        end

        al_hr_nxt_s  = al_hr_r;
        al_min_nxt_s = al_min_r;
        armed_nxt_s  = armed_r;
        if (al_req_s) begin
            armed_nxt_s = al_ok_s;
            if (al_ok_s) begin
                al_hr_nxt_s  = bus.al_hr;
                al_min_nxt_s = bus.al_min;
            end else begin
                al_hr_nxt_s  = al_hr_r;
            end
        end else begin
            armed_nxt_s = armed_r;
        end

        if (bus.load || al_req_s) begin
            load_err_nxt_s = (bus.load && !ld_ok_s) || (al_req_s && !al_ok_s);
        end else begin
            load_err_nxt_s = load_err_r;
        end

        // Fire takes precedence over a same-cycle acknowledge.
        if (fire_s) begin
            alarm_nxt_s = 1'b1;
        end else if (bus.alarm_ack) begin
            alarm_nxt_s = 1'b0;
        end else begin
            alarm_nxt_s = alarm_r;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge hundred_clk or posedge rst) begin
        if (rst) begin
            presc_r    <= '0;
            hr_r       <= 8'h00;
            min_r      <= 8'h00;
            sec_r      <= 8'h00;
            al_hr_r    <= 8'h00;
            al_min_r   <= 8'h00;
            armed_r    <= 1'b0;
            alarm_r    <= 1'b0;
            load_err_r <= 1'b0;
            sec_tick_r <= 1'b0;
        end else begin
            presc_r    <= presc_nxt_s;
            hr_r       <= hr_nxt_s;
            min_r      <= min_nxt_s;
            sec_r      <= sec_nxt_s;
            al_hr_r    <= al_hr_nxt_s;
            al_min_r   <= al_min_nxt_s;
            armed_r    <= armed_nxt_s;
            alarm_r    <= alarm_nxt_s;
            load_err_r <= load_err_nxt_s;
            sec_tick_r <= adv_s;
        end
    end

    assign bus.hr       = bus.mode12 ? hr_to_12(hr_r) : hr_r;
    assign bus.min      = min_r;
    assign bus.sec      = sec_r;
    assign bus.pm       = bus.mode12 && (hr_r >= 8'h12);
    assign bus.sec_tick = sec_tick_r;
    assign bus.alarm    = alarm_r;
    assign bus.load_err = load_err_r;

endmodule

// File: tb/tb_rtc_bcd_settable.sv
// ---------------------------------------------------------------------------
// tb_rtc_bcd_settable
// Directed, table-driven bench for rtc_bcd_settable with TICKS_PER_SEC=4.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_rtc_bcd_settable;

    logic hundred_clk;
    logic rst;
    int   checks;
    int   failures;

    rtc_bcd_settable_if bus_if();

    rtc_bcd_settable #(
        .TICKS_PER_SEC (4),
        .ALARM_EN      (1)
    ) dut (
        .hundred_clk (hundred_clk),
        .rst         (rst),
        .bus         (bus_if)
    );

    initial hundred_clk = 1'b0;
    always #5 hundred_clk = ~hundred_clk;

    typedef struct {
        logic       do_load;
        logic [7:0] lh;
        logic [7:0] lm;
        logic [7:0] ls;
        int         n_run;
        logic       m12;
        logic [7:0] e_hr;
        logic [7:0] e_min;
        logic [7:0] e_sec;
        logic       e_pm;
        logic       e_err;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge hundred_clk);
        @(negedge hundred_clk);
    endtask

    task automatic do_load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        bus_if.ld_hr  = h;
        bus_if.ld_min = m;
        bus_if.ld_sec = s;
        bus_if.load   = 1'b1;
        tick();
        bus_if.load   = 1'b0;
    endtask

    task automatic check_time(input string name, input logic [7:0] h, input logic [7:0] m,
                              input logic [7:0] s);
        check({name, "_hr"}, bus_if.hr, h);
        check({name, "_min"}, bus_if.min, m);
        check({name, "_sec"}, bus_if.sec, s);
    endtask

    initial begin
        int pulses;
        int bad;
        checks   = 0;
        failures = 0;

        // row: load?, ld hh:mm:ss, run cycles, mode12, expected hr(display), min, sec, pm, load_err
        vecs[0]  = '{1'b1, 8'h23, 8'h59, 8'h58, 4, 1'b1, 8'h11, 8'h59, 8'h59, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 8'h00, 8'h00, 8'h00, 4, 1'b1, 8'h12, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 8'h24, 8'h00, 8'h00, 0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1};
        vecs[3]  = '{1'b1, 8'h12, 8'h6A, 8'h00, 0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1};
        vecs[4]  = '{1'b1, 8'h01, 8'h02, 8'h03, 0, 1'b0, 8'h01, 8'h02, 8'h03, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 8'h12, 8'h00, 8'h00, 0, 1'b1, 8'h12, 8'h00, 8'h00, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 8'h13, 8'h45, 8'h07, 0, 1'b1, 8'h01, 8'h45, 8'h07, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 8'h22, 8'h00, 8'h59, 4, 1'b1, 8'h10, 8'h01, 8'h00, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 8'h09, 8'h59, 8'h59, 4, 1'b0, 8'h10, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 8'h19, 8'h59, 8'h59, 4, 1'b1, 8'h08, 8'h00, 8'h00, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 8'h1A, 8'h00, 8'h00, 0, 1'b0, 8'h20, 8'h00, 8'h00, 1'b0, 1'b1};
        vecs[11] = '{1'b1, 8'h05, 8'h10, 8'h3A, 0, 1'b1, 8'h08, 8'h00, 8'h00, 1'b1, 1'b1};
        vecs[12] = '{1'b1, 8'h00, 8'h00, 8'h00, 0, 1'b1, 8'h12, 8'h00, 8'h00, 1'b0, 1'b0};

        rst              = 1'b1;
        bus_if.run       = 1'b0;
        bus_if.mode12    = 1'b0;
        bus_if.load      = 1'b0;
        bus_if.ld_hr     = 8'h00;
        bus_if.ld_min    = 8'h00;
        bus_if.ld_sec    = 8'h00;
        bus_if.alarm_set = 1'b0;
        bus_if.al_hr     = 8'h00;
        bus_if.al_min    = 8'h00;
        bus_if.alarm_ack = 1'b0;

        // Reset values in both display modes.
        @(negedge hundred_clk);
        tick();
        check_time("rst24", 8'h00, 8'h00, 8'h00);
        check("rst_pm", bus_if.pm, 1'b0);
        check("rst_tick", bus_if.sec_tick, 1'b0);
        check("rst_alarm", bus_if.alarm, 1'b0);
        check("rst_err", bus_if.load_err, 1'b0);
        bus_if.mode12 = 1'b1;
        #1;
        check("rst12_hr", bus_if.hr, 8'h12);
        check("rst12_pm", bus_if.pm, 1'b0);
        bus_if.mode12 = 1'b0;
        rst = 1'b0;

        // 40 running cycles: a tick every 4th cycle, 10 seconds.
        bus_if.run = 1'b1;
        pulses = 0;
        bad    = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (bus_if.sec_tick === 1'b1) pulses++;
            if (bus_if.sec_tick !== ((i % 4) == 0)) bad++;
        end
        bus_if.run = 1'b0;
        check("run40_sec", bus_if.sec, 8'h10);
        check("run40_pulses", pulses, 10);
        check("run40_tick_pattern", bad, 0);

        // Table: loads, carries, range rejection, 12-hour formatting.
        for (int v = 0; v < 13; v++) begin
            if (vecs[v].do_load) begin
                do_load(vecs[v].lh, vecs[v].lm, vecs[v].ls);
            end
            bus_if.run = (vecs[v].n_run > 0);
            for (int c = 0; c < vecs[v].n_run; c++) tick();
            bus_if.run    = 1'b0;
            bus_if.mode12 = vecs[v].m12;
            #1;
            check_time($sformatf("vec%0d", v), vecs[v].e_hr, vecs[v].e_min, vecs[v].e_sec);
            check($sformatf("vec%0d_pm", v), bus_if.pm, vecs[v].e_pm);
            check($sformatf("vec%0d_err", v), bus_if.load_err, vecs[v].e_err);
        end

        // Alarm arm, fire with ack in the fire cycle, then clear.
        bus_if.al_hr     = 8'h07;
        bus_if.al_min    = 8'h30;
        bus_if.alarm_set = 1'b1;
        tick();
        bus_if.alarm_set = 1'b0;
        check("alset_err", bus_if.load_err, 1'b0);
        do_load(8'h07, 8'h29, 8'h59);
        bus_if.run = 1'b1;
        repeat (3) tick();
        check("alarm_early", bus_if.alarm, 1'b0);
        bus_if.alarm_ack = 1'b1;
        tick();
        check("alarm_fire", bus_if.alarm, 1'b1);
        check("alarm_fire_tick", bus_if.sec_tick, 1'b1);
        check_time("alarm_fire", 8'h07, 8'h30, 8'h00);
        tick();
        bus_if.alarm_ack = 1'b0;
        check("alarm_ack", bus_if.alarm, 1'b0);
        bus_if.run = 1'b0;

        // Loading the alarm time does not fire it.
        do_load(8'h07, 8'h30, 8'h00);
        check("alarm_on_load", bus_if.alarm, 1'b0);

        // Freeze mid-count: prescaler at 2, hold 10 cycles, resume needs 2 more.
        bus_if.run = 1'b1;
        repeat (2) tick();
        bus_if.run = 1'b0;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus_if.sec_tick === 1'b1) pulses++;
        end
        check("freeze_pulses", pulses, 0);
        check_time("freeze", 8'h07, 8'h30, 8'h00);
        bus_if.run = 1'b1;
        tick();
        check("resume_tick1", bus_if.sec_tick, 1'b0);
        tick();
        check("resume_tick2", bus_if.sec_tick, 1'b1);
        check("resume_sec", bus_if.sec, 8'h01);

        // Load coincident with a prescaler wrap.
        repeat (3) tick();
        do_load(8'h11, 8'h22, 8'h33);
        check("ldwrap_tick", bus_if.sec_tick, 1'b0);
        check_time("ldwrap", 8'h11, 8'h22, 8'h33);
        repeat (3) tick();
        check("ldwrap_hold_sec", bus_if.sec, 8'h33);
        check("ldwrap_hold_tick", bus_if.sec_tick, 1'b0);
        tick();
        check("ldwrap_adv_sec", bus_if.sec, 8'h34);
        check("ldwrap_adv_tick", bus_if.sec_tick, 1'b1);
        bus_if.run = 1'b0;

        // Valid load with rejected alarm_set in the same cycle disarms the alarm.
        bus_if.ld_hr     = 8'h07;
        bus_if.ld_min    = 8'h29;
        bus_if.ld_sec    = 8'h59;
        bus_if.al_hr     = 8'h25;
        bus_if.al_min    = 8'h30;
        bus_if.load      = 1'b1;
        bus_if.alarm_set = 1'b1;
        tick();
        bus_if.load      = 1'b0;
        bus_if.alarm_set = 1'b0;
        check("dual_err", bus_if.load_err, 1'b1);
        check_time("dual", 8'h07, 8'h29, 8'h59);
        bus_if.run = 1'b1;
        repeat (4) tick();
        check_time("disarmed", 8'h07, 8'h30, 8'h00);
        check("disarmed_alarm", bus_if.alarm, 1'b0);

        // Asynchronous reset mid-cycle with a pending load.
        bus_if.ld_hr  = 8'h01;
        bus_if.ld_min = 8'h01;
        bus_if.ld_sec = 8'h01;
        bus_if.load   = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check_time("async_rst", 8'h12, 8'h00, 8'h00);
        check("async_rst_pm", bus_if.pm, 1'b0);
        check("async_rst_err", bus_if.load_err, 1'b0);
        check("async_rst_tick", bus_if.sec_tick, 1'b0);
        @(negedge hundred_clk);
        tick();
        bus_if.load = 1'b0;
        bus_if.run  = 1'b0;
        rst = 1'b0;
        tick();
        check_time("post_rst", 8'h12, 8'h00, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
